systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N systolic array of PE accumulators.
- On a start request it clears all accumulators, streams K operand pairs from the A/B operand buffers with per-row diagonal skew, and waits out array fill and MAC latency.
- It then drains the N result rows to a downstream sink through a valid/ready handshake.
- Sits between the host command interface and the PE grid / operand buffers.

Parameters:
N, 4, array dimension (rows = columns)
K_MAX, 16, maximum reduction length
AW, 8, operand buffer address width (2**AW >= K_MAX)
LAT, 2, PE pipeline latency (input register + MAC/accumulate)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_start  input  1  start request, sampled only in IDLE
i_k_len  input  $clog2(K_MAX+1)  reduction length K for this job
i_mode  input  1  MAC mode for this job
i_res_ready  input  1  downstream accepts current result row
o_busy  output  1  high in every state except IDLE
o_err  output  1  one-cycle pulse: start rejected
o_sync  output  1  accumulator clear to every PE
o_en  output  1  array enable
o_mode  output  1  latched job mode to every PE
o_rd_en  output  1  operand buffer read strobe
o_rd_addr  output  AW  operand buffer read address
o_feed_mask  output  N  bit r = row/column r injects a valid operand this cycle, else zero is injected
o_res_valid  output  1  result row available
o_drain_row  output  $clog2(N)  index of the row being presented
o_done  output  1  one-cycle pulse: job complete

Behaviour:
- Reset: synchronous to i_clk, active when i_rst_n is low.
  - Every output is 0; state is IDLE; counters and latched K/mode are 0.
  - Reset mid-job aborts immediately with no o_done or o_err.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE, cycle c where i_start=1:
  - If 1 <= i_k_len <= K_MAX: latch K and mode; CLEAR in c+1.
  - Otherwise: o_err=1 in c+1 and stay IDLE.
  - i_start outside IDLE is ignored.
- CLEAR: exactly 1 cycle, o_sync=1, o_en=0.
- FEED: K+N-1 cycles, local index t=0..K+N-2.
  - o_en=1.
  - o_rd_en=1 and o_rd_addr=t for t<K, else o_rd_en=0 and o_rd_addr=0.
  - o_feed_mask[r]=1 iff r <= t <= r+K-1; the buffer side applies the skew using this mask.
- FLUSH: N-1+LAT cycles, o_en=1, o_feed_mask=0, o_rd_en=0.
- DRAIN: o_en=0, o_res_valid=1, o_drain_row starts at 0.
  - A transfer occurs on any cycle with o_res_valid & i_res_ready; the row then increments.
  - o_drain_row holds while i_res_ready=0, with no timeout.
  - A transfer on row N-1 goes to DONE.
- DONE: 1 cycle, o_done=1, o_busy=1; then IDLE, where o_busy=0 and a new start is accepted the same cycle.
- o_mode holds the latched mode from CLEAR through DONE; it returns to 0 only on reset.
- Total job length with i_res_ready held high: 1 + (K+N-1) + (N-1+LAT) + N + 1 cycles.
- Counters are sized for K_MAX+N; no wrap-around occurs for legal K.

Test Plan:
- N=4, LAT=2, K=3, i_res_ready=1, start sampled in cycle 0 -> required timing:
  - o_sync=1 only in cycle 1.
  - FEED cycles 2-7: o_rd_addr 0,1,2; o_feed_mask 0001,0011,0111,1110,1100,1000.
  - FLUSH cycles 8-12 with o_en=1.
  - o_res_valid cycles 13-16 with rows 0-3.
  - o_done in cycle 17.
- Same job, i_res_ready low for 3 cycles at row 2 -> o_drain_row stays 2 for 4 cycles; o_done delayed by 3 cycles; no row skipped.
- i_k_len=0 and i_k_len=17 -> o_err single pulse each; o_busy stays 0; no o_sync.
- i_start held high through a K=1 job -> second start ignored while busy; a new job begins (o_sync) 2 cycles after o_done.
- i_rst_n low during FEED, t=2 -> next cycle all outputs 0 and state IDLE; a following start behaves like the first scenario.
- K=K_MAX=16, i_mode=1 -> o_rd_addr covers 0-15 exactly once; o_mode=1 from CLEAR through DONE; FEED lasts 19 cycles.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an N x N systolic array of PE accumulators.
// Clears the accumulators, streams K skewed operand pairs, waits out array
// fill and MAC latency, then drains N result rows over a valid/ready handshake.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int AW    = 8,
    parameter int LAT   = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [$clog2(K_MAX+1)-1:0]   i_k_len,
    input  logic                         i_mode,
    input  logic                         i_res_ready,
    output logic                         o_busy,
    output logic                         o_err,
    output logic                         o_sync,
    output logic                         o_en,
    output logic                         o_mode,
    output logic                         o_rd_en,
    output logic [AW-1:0]                o_rd_addr,
    output logic [N-1:0]                 o_feed_mask,
    output logic                         o_res_valid,
    output logic [$clog2(N)-1:0]         o_drain_row,
    output logic                         o_done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = $clog2(N);
    // Wide enough for the longest phase (FEED: K_MAX+N-1 cycles) plus margin.
    localparam int CW = $clog2(K_MAX + 2 * N + LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_k;
    logic            r_mode;
    logic            r_err;

    logic            w_k_ok;
    logic            w_accept;
    logic            w_feed_last;
    logic            w_flush_last;
    logic            w_drain_last;
    logic            w_cnt_step;

    // Start acceptance and phase-end decodes
    always_comb begin
        w_k_ok       = (i_k_len != '0) && (i_k_len <= KW'(K_MAX));
        w_accept     = (r_state == S_IDLE) && i_start && w_k_ok;
        w_feed_last  = (r_cnt == (CW'(r_k) + CW'(N) - CW'(2)));
        w_flush_last = (r_cnt == CW'(N + LAT - 2));
        w_drain_last = (r_cnt == CW'(N - 1));
        w_cnt_step   = (r_state == S_FEED) || (r_state == S_FLUSH) ||
                       ((r_state == S_DRAIN) && i_res_ready);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_FEED;
            S_FEED:  if (w_feed_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (i_res_ready && w_drain_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter (restarts on every state change), job latches, error pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_k    <= '0;
            r_mode <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && i_start && !w_k_ok;
            if (w_accept) begin
                r_k    <= i_k_len;
                r_mode <= i_mode;
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_step) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Output decode from state and phase counter
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_err       = r_err;
        o_mode      = r_mode;
        o_sync      = 1'b0;
        o_en        = 1'b0;
        o_rd_en     = 1'b0;
        o_rd_addr   = '0;
        o_feed_mask = '0;
        o_res_valid = 1'b0;
        o_drain_row = '0;
        o_done      = 1'b0;
        case (r_state)
            S_CLEAR: o_sync = 1'b1;
            S_FEED: begin
                o_en = 1'b1;
                if (r_cnt < CW'(r_k)) begin
                    o_rd_en   = 1'b1;
                    o_rd_addr = AW'(r_cnt);
                end
                // Row r is live for the K cycles starting at t = r (diagonal skew).
                for (int unsigned r = 0; r < N; r++) begin
                    o_feed_mask[r] = (r_cnt >= CW'(r)) &&
                                     (r_cnt < (CW'(r) + CW'(r_k)));
                end
            end
            S_FLUSH: o_en = 1'b1;
            S_DRAIN: begin
                o_res_valid = 1'b1;
                o_drain_row = r_cnt[RW-1:0];
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed job scenarios plus random
// traffic, compared every cycle against an elapsed-time job model.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int AW    = 8;
    localparam int LAT   = 2;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int RW    = $clog2(N);

    logic          clk = 1'b0;
    logic          i_rst_n, i_start, i_mode, i_res_ready;
    logic [KW-1:0] i_k_len;
    logic          o_busy, o_err, o_sync, o_en, o_mode, o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [N-1:0]  o_feed_mask;
    logic          o_res_valid, o_done;
    logic [RW-1:0] o_drain_row;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .K_MAX(K_MAX), .AW(AW), .LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_k_len(i_k_len),
        .i_mode(i_mode), .i_res_ready(i_res_ready), .o_busy(o_busy),
        .o_err(o_err), .o_sync(o_sync), .o_en(o_en), .o_mode(o_mode),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_feed_mask(o_feed_mask),
        .o_res_valid(o_res_valid), .o_drain_row(o_drain_row), .o_done(o_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Job model: a job is described by cycles elapsed since acceptance and
    // the number of result rows already transferred.
    bit m_active, m_mode, m_err;
    int m_e, m_k, m_row;

    // Per-scenario statistics gathered from observed outputs
    int st_busy, st_rd, st_sync, st_err, st_done, st_mask_cyc, st_row2, st_mode_busy;
    logic [15:0] st_addr;

    task automatic clear_stats();
        st_busy = 0; st_rd = 0; st_sync = 0; st_err = 0; st_done = 0;
        st_mask_cyc = 0; st_row2 = 0; st_mode_busy = 0; st_addr = '0;
    endtask

    task automatic compare_outputs();
        logic          e_busy, e_sync, e_en, e_rd, e_valid, e_done;
        logic [AW-1:0] e_addr;
        logic [N-1:0]  e_mask;
        int            e_row, t, feed_end, flush_end;
        e_busy = 0; e_sync = 0; e_en = 0; e_rd = 0; e_valid = 0; e_done = 0;
        e_addr = '0; e_mask = '0; e_row = 0;
        feed_end  = m_k + N;               // FEED occupies e = 2 .. K+N
        flush_end = m_k + 2 * N + LAT - 1; // FLUSH is the next N-1+LAT cycles
        if (m_active) begin
            e_busy = 1;
            if (m_e == 1) e_sync = 1;
            else if (m_e <= feed_end) begin
                t = m_e - 2;
                e_en = 1;
                if (t < m_k) begin
                    e_rd = 1;
                    e_addr = AW'(t);
                end
                for (int r = 0; r < N; r++) e_mask[r] = (t >= r) && (t <= r + m_k - 1);
            end else if (m_e <= flush_end) e_en = 1;
            else if (m_row < N) begin
                e_valid = 1;
                e_row = m_row;
            end else e_done = 1;
        end
        check("busy", o_busy, e_busy);
        check("err", o_err, m_err);
        check("sync", o_sync, e_sync);
        check("en", o_en, e_en);
        check("mode", o_mode, m_mode);
        check("rd_en", o_rd_en, e_rd);
        check("rd_addr", o_rd_addr, e_addr);
        check("feed_mask", o_feed_mask, e_mask);
        check("res_valid", o_res_valid, e_valid);
        check("drain_row", o_drain_row, e_row);
        check("done", o_done, e_done);

        st_busy += int'(o_busy);
        st_sync += int'(o_sync);
        st_err  += int'(o_err);
        st_done += int'(o_done);
        if (o_rd_en === 1'b1) begin
            st_rd++;
            if (o_rd_addr < 16) st_addr[o_rd_addr[3:0]] = 1'b1;
        end
        if (o_en === 1'b1 && o_feed_mask != '0) st_mask_cyc++;
        if (o_res_valid === 1'b1 && o_drain_row == 2) st_row2++;
        if (o_busy === 1'b1 && o_mode === 1'b1) st_mode_busy++;
    endtask

    task automatic model_step(input logic st, input logic [KW-1:0] k, input logic md,
                              input logic rdy, input logic rstn);
        if (!rstn) begin
            m_active = 0; m_e = 0; m_k = 0; m_row = 0; m_mode = 0; m_err = 0;
        end else if (!m_active) begin
            m_err = st && (k == 0 || int'(k) > K_MAX);
            if (st && k != 0 && int'(k) <= K_MAX) begin
                m_active = 1; m_e = 1; m_k = int'(k); m_mode = md; m_row = 0;
            end
        end else begin
            m_err = 0;
            if (m_e > m_k + 2 * N + LAT - 1) begin
                if (m_row == N) m_active = 0;
                else if (rdy) m_row++;
            end
            m_e++;
        end
    endtask

    // One clock cycle: check this cycle's outputs, then drive its inputs.
    task automatic cyc(input logic st, input logic [KW-1:0] k, input logic md,
                       input logic rdy, input logic rstn);
        @(negedge clk);
        compare_outputs();
        i_start = st; i_k_len = k; i_mode = md; i_res_ready = rdy; i_rst_n = rstn;
        model_step(st, k, md, rdy, rstn);
    endtask

    initial begin
        i_rst_n = 0; i_start = 0; i_k_len = '0; i_mode = 0; i_res_ready = 1;
        model_step(0, '0, 0, 1, 0);
        clear_stats();

        // Reset state, with start asserted to show it is ignored in reset
        cyc(1, 5'd3, 1, 1, 0);
        cyc(0, 5'd0, 0, 1, 0);
        cyc(0, 5'd0, 0, 1, 1);

        // K=3 job, ready held high
        clear_stats();
        cyc(1, 5'd3, 0, 1, 1);
        for (int j = 1; j <= 20; j++) cyc(0, 5'd0, 0, 1, 1);
        check("k3_busy_cycles", st_busy, 17);
        check("k3_rd_cycles", st_rd, 3);
        check("k3_done_count", st_done, 1);

        // K=3 job with ready low for 3 cycles while row 2 is presented
        clear_stats();
        cyc(1, 5'd3, 0, 1, 1);
        for (int j = 1; j <= 23; j++) cyc(0, 5'd0, 0, !(j >= 15 && j <= 17), 1);
        check("stall_busy_cycles", st_busy, 20);
        check("stall_row2_cycles", st_row2, 4);

        // Illegal lengths
        clear_stats();
        cyc(1, 5'd0, 0, 1, 1);
        for (int j = 0; j < 3; j++) cyc(0, 5'd0, 0, 1, 1);
        cyc(1, 5'd17, 1, 1, 1);
        for (int j = 0; j < 3; j++) cyc(0, 5'd0, 0, 1, 1);
        check("bad_k_err_pulses", st_err, 2);
        check("bad_k_sync", st_sync, 0);
        check("bad_k_busy", st_busy, 0);

        // Start held high through back-to-back K=1 jobs
        clear_stats();
        for (int j = 0; j < 30; j++) cyc(1, 5'd1, 0, 1, 1);
        check("held_sync_count", st_sync, 2);
        check("held_done_count", st_done, 1);
        for (int j = 0; j < 20; j++) cyc(0, 5'd0, 0, 1, 1);

        // Reset during FEED at t=2, then a clean K=3 job
        cyc(1, 5'd3, 0, 1, 1);
        for (int j = 1; j <= 3; j++) cyc(0, 5'd0, 0, 1, 1);
        cyc(0, 5'd0, 0, 1, 0);
        cyc(0, 5'd0, 0, 1, 1);
        clear_stats();
        cyc(1, 5'd3, 0, 1, 1);
        for (int j = 1; j <= 20; j++) cyc(0, 5'd0, 0, 1, 1);
        check("post_rst_busy_cycles", st_busy, 17);

        // K=K_MAX, mode 1
        clear_stats();
        cyc(1, 5'd16, 1, 1, 1);
        for (int j = 1; j <= 40; j++) cyc(0, 5'd0, 0, 1, 1);
        check("kmax_rd_cycles", st_rd, 16);
        check("kmax_addr_cover", st_addr, 16'hFFFF);
        check("kmax_feed_cycles", st_mask_cyc, 19);
        check("kmax_busy_cycles", st_busy, 30);
        check("kmax_mode_busy", st_mode_busy, 30);

        // Random traffic
        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom_range(0, 3) == 0), KW'($urandom_range(0, 17)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 299) != 0));
        end
        cyc(0, 5'd0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
